// File: rtl/registrador_universal_if.sv
// Bus bundle for registrador_universal: the mode/data controls and the register outputs.
interface registrador_universal_if #(
  parameter int WIDTH = 8
);
  logic             enable;
  logic [2:0]       mode;
  logic [WIDTH-1:0] D;
  logic             serial_in_right;
  logic             serial_in_left;
  logic [WIDTH-1:0] Q;
  logic             carry;
  logic             zero;

  modport master (
    output enable, mode, D, serial_in_right, serial_in_left,
    input  Q, carry, zero
  );

  modport slave (
    input  enable, mode, D, serial_in_right, serial_in_left,
    output Q, carry, zero
  );
endinterface

// File: rtl/registrador_universal.sv
// WIDTH-bit multi-mode register (hold/load/shift/inc/dec) with carry and zero flags.
// Define REGISTRADOR_UNIVERSAL_ROTATE_EN to turn modes 110/111 into rotate left/right.
module registrador_universal #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input logic                     clock_i,
  input logic                     clear_i,
  registrador_universal_if.slave  bus
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_INC  = 3'b100;
  localparam logic [2:0] MODE_DEC  = 3'b101;
  localparam logic [2:0] MODE_ROL  = 3'b110;
  localparam logic [2:0] MODE_ROR  = 3'b111;

  logic [WIDTH-1:0] q_q, q_d;
  logic             carry_q, carry_d;
  logic [WIDTH:0]   ext;

  // Arithmetic is done one bit wider so the top bit is the carry/borrow.
  assign ext = {1'b0, q_q};

  always_comb begin
    q_d     = q_q;
    carry_d = carry_q;
    if (bus.enable) begin
      case (bus.mode)
        MODE_HOLD: ;
        MODE_LOAD: begin
          q_d     = bus.D;
          carry_d = 1'b0;
        end
        MODE_SHL:  {carry_d, q_d} = {q_q, bus.serial_in_right};
        MODE_SHR:  {q_d, carry_d} = {bus.serial_in_left, q_q};
        MODE_INC:  {carry_d, q_d} = ext + 1'b1;
        MODE_DEC:  {carry_d, q_d} = ext - 1'b1;
`ifdef REGISTRADOR_UNIVERSAL_ROTATE_EN
        MODE_ROL:  {carry_d, q_d} = {q_q, q_q[WIDTH-1]};
        MODE_ROR:  {q_d, carry_d} = {q_q[0], q_q};
`else
        MODE_ROL, MODE_ROR: ;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (clear_i) begin
      q_q     <= RESET_VALUE;
      carry_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      carry_q <= carry_d;
    end
  end

  assign bus.Q     = q_q;
  assign bus.carry = carry_q;
  assign bus.zero  = (q_q == '0);

endmodule

// File: tb/tb_registrador_universal.sv
// Self-checking bench for registrador_universal: directed vector table plus a randomised model run.
module tb_registrador_universal;

  localparam int         W  = 8;
  localparam logic [7:0] RV = 8'hA5;

  typedef struct {
    logic       clr;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sir;
    logic       sil;
    logic [7:0] eq;
    logic       ec;
    logic       ez;
  } vec_t;

  logic clk = 1'b0;
  logic clr;
  int   total = 0;
  int   bad   = 0;

  vec_t vecs[25];
  vec_t exp_fifo[$];

  registrador_universal_if #(.WIDTH(W)) bus ();

  registrador_universal #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .clock_i (clk),
    .clear_i (clr),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic c, input logic e, input logic [2:0] m,
                              input logic [7:0] d, input logic sir, input logic sil,
                              input logic [7:0] eq, input logic ec, input logic ez);
    vec_t v;
    v.clr = c; v.en = e; v.mode = m; v.d = d; v.sir = sir; v.sil = sil;
    v.eq = eq; v.ec = ec; v.ez = ez;
    return v;
  endfunction

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    @(negedge clk);
    clr                 = v.clr;
    bus.enable          = v.en;
    bus.mode            = v.mode;
    bus.D               = v.d;
    bus.serial_in_right = v.sir;
    bus.serial_in_left  = v.sil;
    exp_fifo.push_back(v);
    @(posedge clk);
    #1;
    e = exp_fifo.pop_front();
    total++;
    if (bus.Q !== e.eq) begin
      bad++;
      $display("FAIL q step=%0d got=%h want=%h", idx, bus.Q, e.eq);
    end
    total++;
    if (bus.carry !== e.ec) begin
      bad++;
      $display("FAIL carry step=%0d got=%b want=%b", idx, bus.carry, e.ec);
    end
    total++;
    if (bus.zero !== e.ez) begin
      bad++;
      $display("FAIL zero step=%0d got=%b want=%b", idx, bus.zero, e.ez);
    end
  endtask

  initial begin
    logic [7:0] m_q;
    logic       m_c;
    vec_t       v;

    clr = 1'b0;
    bus.enable = 1'b0; bus.mode = 3'b000; bus.D = '0;
    bus.serial_in_right = 1'b0; bus.serial_in_left = 1'b0;

    vecs[0]  = mk(1, 1, 3'b001, 8'h3C, 0, 0, 8'hA5, 0, 0);
    vecs[1]  = mk(0, 1, 3'b001, 8'h00, 0, 0, 8'h00, 0, 1);
    vecs[2]  = mk(0, 0, 3'b001, 8'hFF, 0, 0, 8'h00, 0, 1);
    vecs[3]  = mk(0, 0, 3'b001, 8'hFF, 0, 0, 8'h00, 0, 1);
    vecs[4]  = mk(0, 0, 3'b001, 8'hFF, 0, 0, 8'h00, 0, 1);
    vecs[5]  = mk(0, 1, 3'b001, 8'hFE, 0, 0, 8'hFE, 0, 0);
    vecs[6]  = mk(0, 1, 3'b100, 8'h00, 0, 0, 8'hFF, 0, 0);
    vecs[7]  = mk(0, 1, 3'b100, 8'h00, 0, 0, 8'h00, 1, 1);
    vecs[8]  = mk(0, 1, 3'b100, 8'h00, 0, 0, 8'h01, 0, 0);
    vecs[9]  = mk(0, 1, 3'b001, 8'h00, 0, 0, 8'h00, 0, 1);
    vecs[10] = mk(0, 1, 3'b101, 8'h00, 0, 0, 8'hFF, 1, 0);
    vecs[11] = mk(0, 1, 3'b101, 8'h00, 0, 0, 8'hFE, 0, 0);
    vecs[12] = mk(0, 1, 3'b001, 8'h81, 0, 0, 8'h81, 0, 0);
    vecs[13] = mk(0, 1, 3'b010, 8'h00, 0, 0, 8'h02, 1, 0);
    vecs[14] = mk(0, 1, 3'b011, 8'h00, 0, 1, 8'h81, 0, 0);
`ifdef REGISTRADOR_UNIVERSAL_ROTATE_EN
    vecs[15] = mk(0, 1, 3'b110, 8'h00, 0, 0, 8'h03, 1, 0);
    vecs[16] = mk(0, 1, 3'b111, 8'h00, 1, 1, 8'h81, 1, 0);
    vecs[17] = mk(0, 1, 3'b000, 8'h55, 1, 1, 8'h81, 1, 0);
`else
    vecs[15] = mk(0, 1, 3'b110, 8'h00, 0, 0, 8'h81, 0, 0);
    vecs[16] = mk(0, 1, 3'b111, 8'h00, 1, 1, 8'h81, 0, 0);
    vecs[17] = mk(0, 1, 3'b000, 8'h55, 1, 1, 8'h81, 0, 0);
`endif
    vecs[18] = mk(0, 1, 3'b001, 8'h7F, 0, 0, 8'h7F, 0, 0);
    vecs[19] = mk(0, 1, 3'b100, 8'h00, 0, 0, 8'h80, 0, 0);
    vecs[20] = mk(1, 1, 3'b100, 8'h00, 0, 0, 8'hA5, 0, 0);
    vecs[21] = mk(0, 1, 3'b000, 8'h00, 0, 0, 8'hA5, 0, 0);
    vecs[22] = mk(0, 1, 3'b010, 8'h00, 1, 0, 8'h4B, 1, 0);
    vecs[23] = mk(0, 0, 3'b100, 8'h00, 0, 0, 8'h4B, 1, 0);
    vecs[24] = mk(0, 1, 3'b101, 8'h00, 0, 0, 8'h4A, 0, 0);

    for (int i = 0; i < 25; i++) apply(vecs[i], i);

    // Randomised back-to-back run against a behavioural model, starting from the last table state.
    m_q = 8'h4A;
    m_c = 1'b0;
    for (int i = 0; i < 300; i++) begin
      v.clr  = ($urandom_range(0, 19) == 0);
      v.en   = ($urandom_range(0, 4) != 0);
      v.mode = 3'($urandom_range(0, 7));
      v.d    = 8'($urandom);
      v.sir  = 1'($urandom);
      v.sil  = 1'($urandom);
      if (v.clr) begin
        m_q = RV;
        m_c = 1'b0;
      end else if (v.en) begin
        case (v.mode)
          3'd1: begin m_q = v.d; m_c = 1'b0; end
          3'd2: begin m_c = m_q[7]; m_q = (m_q << 1) | {7'd0, v.sir}; end
          3'd3: begin m_c = m_q[0]; m_q = (m_q >> 1) | {v.sil, 7'd0}; end
          3'd4: begin m_c = (m_q == 8'hFF); m_q = m_q + 8'd1; end
          3'd5: begin m_c = (m_q == 8'h00); m_q = m_q - 8'd1; end
`ifdef REGISTRADOR_UNIVERSAL_ROTATE_EN
          3'd6: begin m_c = m_q[7]; m_q = (m_q << 1) | {7'd0, m_q[7]}; end
          3'd7: begin m_c = m_q[0]; m_q = (m_q >> 1) | {m_q[0], 7'd0}; end
`endif
          default: ;
        endcase
      end
      v.eq = m_q;
      v.ec = m_c;
      v.ez = (m_q == 8'h00);
      apply(v, 100 + i);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
